// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: coefficient and enable controller for the 12-tap FIR.
// Holds a shadow bank loaded from the slow-control bus and an active bank
// that drives the filter. A commit copies shadow to active in one edge, and
// the filter is then kept in bypass for FLUSH_CYCLES so that no output sample
// mixes old and new coefficients.
// Optional feature macro: FIR_COEFF_READBACK_EN adds a registered readback
// port (RD_ADDR / RD_SEL / RD_DATA) for either bank.
module fir_coeff_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter logic [15:0] RESET_C0     = 16'h2000
) (
  input  logic         CLK,
  input  logic         RSTb,
  input  logic         WR_EN,
  input  logic [3:0]   WR_ADDR,
  input  logic [15:0]  WR_DATA,
  input  logic         COMMIT,
  input  logic         FIR_REQ,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [3:0]   RD_ADDR,
  input  logic         RD_SEL,
  output logic [15:0]  RD_DATA,
`endif
  output logic         ENABLE_FIR,
  output logic [191:0] COEFF_BUS,
  output logic         BUSY,
  output logic         ERR_ADDR,
  output logic [7:0]   COMMIT_CNT
);

  localparam int NTAPS = 12;
  // Counter load value; the FLUSH state itself lasts FLUSH_CYCLES edges.
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SWAP  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        enable_q, enable_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  commit_cnt_q, commit_cnt_d;
  logic        copy_bank;

  logic [15:0] shadow_q [NTAPS];
  logic [15:0] shadow_d [NTAPS];
  logic [15:0] active_q [NTAPS];
  logic [15:0] active_d [NTAPS];

  // Control FSM: next state, filter enable, busy flag and commit counter.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    enable_d     = enable_q;
    busy_d       = busy_q;
    commit_cnt_d = commit_cnt_q;
    copy_bank    = 1'b0;
    case (state_q)
      ST_RUN: begin
        enable_d = FIR_REQ;
        if (COMMIT) begin
          state_d      = ST_SWAP;
          enable_d     = 1'b0;
          busy_d       = 1'b1;
          commit_cnt_d = commit_cnt_q + 8'd1;
        end
      end
      ST_SWAP: begin
        copy_bank   = 1'b1;
        flush_cnt_d = FLUSH_LOAD;
        enable_d    = 1'b0;
        state_d     = ST_FLUSH;
      end
      ST_FLUSH: begin
        enable_d = 1'b0;
        if (flush_cnt_q != 8'd0) begin
          flush_cnt_d = flush_cnt_q - 8'd1;
        end else begin
          state_d  = ST_RUN;
          busy_d   = 1'b0;
          enable_d = FIR_REQ;
        end
      end
      default: begin
        state_d  = ST_RUN;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Bank update: the copy reads shadow_q, so a write on the SWAP edge stays
  // in shadow only and is picked up by the next commit.
  always_comb begin
    err_d = err_q;
    for (int k = 0; k < NTAPS; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = copy_bank ? shadow_q[k] : active_q[k];
      if (WR_EN && (WR_ADDR == 4'(k))) begin
        shadow_d[k] = WR_DATA;
      end
    end
    if (WR_EN && (WR_ADDR > 4'd11)) begin
      err_d = 1'b1;
    end
  end

  // State and bank registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= 8'd0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      commit_cnt_q <= 8'd0;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == 0) ? RESET_C0 : 16'h0000;
        active_q[k] <= (k == 0) ? RESET_C0 : 16'h0000;
      end
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      commit_cnt_q <= commit_cnt_d;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  // Flatten the active bank onto the coefficient bus, tap k at [16k+15:16k].
  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_bus
      assign COEFF_BUS[16*gi +: 16] = active_q[gi];
    end
  endgenerate

  assign ENABLE_FIR = enable_q;
  assign BUSY       = busy_q;
  assign ERR_ADDR   = err_q;
  assign COMMIT_CNT = commit_cnt_q;

`ifdef FIR_COEFF_READBACK_EN
  logic [15:0] rd_data_q, rd_data_d;

  // Readback mux: out-of-range addresses return zero.
  always_comb begin
    rd_data_d = 16'h0000;
    for (int k = 0; k < NTAPS; k++) begin
      if (RD_ADDR == 4'(k)) begin
        rd_data_d = RD_SEL ? active_q[k] : shadow_q[k];
      end
    end
  end

  // Registered readback data, one cycle latency.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rd_data_q <= 16'h0000;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign RD_DATA = rd_data_q;
`endif

endmodule
